armleocpu_tlb_asid: RTL

- Set-associative, ASID-tagged TLB. Parametrised successor of the single-address-space TLB: configurable sets, ways and ASID width.
- Adds global-page handling, selective invalidation (by VPN, by ASID, or both, per RISC-V sfence.vma semantics) and duplicate-free refill.
- Sits between the fetch/LSU address path and the page-table walker. Entries are held in flops.

---
 rtl/armleocpu_tlb_asid.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/armleocpu_tlb_asid.sv
// armleocpu_tlb_asid: set-associative, ASID-tagged TLB held in flops.
// Supports global pages, selective sfence.vma-style invalidation and
// refill that overwrites an existing match instead of duplicating it.
module armleocpu_tlb_asid #(
  parameter int ENTRIES_W = 4,
  parameter int WAYS      = 2,
  parameter int ASID_W    = 9,
  localparam int WAYS_W   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        cmd,
  input  logic [19:0]       vaddr_input,
  input  logic [ASID_W-1:0] asid_input,
  input  logic [7:0]        new_entry_metadata_input,
  input  logic [21:0]       new_entry_ptag_input,
  output logic              resolve_valid,
  output logic              hit,
  output logic [7:0]        resolve_metadata_output,
  output logic [21:0]       resolve_ptag_output,
  output logic [WAYS_W-1:0] resolve_way
);

  localparam int SETS  = 1 << ENTRIES_W;
  localparam int TAG_W = 20 - ENTRIES_W;
  localparam int G_BIT = 5;

  localparam logic [2:0] CMD_RESOLVE          = 3'd1;
  localparam logic [2:0] CMD_NEW_ENTRY        = 3'd2;
  localparam logic [2:0] CMD_INVALIDATE_ALL   = 3'd3;
  localparam logic [2:0] CMD_INVALIDATE_VADDR = 3'd4;
  localparam logic [2:0] CMD_INVALIDATE_ASID  = 3'd5;
  localparam logic [2:0] CMD_INVALIDATE_VA_AS = 3'd6;

  // Entry storage
  logic              valid_q [SETS][WAYS];
  logic              valid_d [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [TAG_W-1:0]  tag_d   [SETS][WAYS];
  logic [ASID_W-1:0] asid_q  [SETS][WAYS];
  logic [ASID_W-1:0] asid_d  [SETS][WAYS];
  logic [7:0]        meta_q  [SETS][WAYS];
  logic [7:0]        meta_d  [SETS][WAYS];
  logic [21:0]       ptag_q  [SETS][WAYS];
  logic [21:0]       ptag_d  [SETS][WAYS];

  logic [WAYS_W-1:0] victim_q, victim_d;

  // Registered resolve outputs
  logic              resolve_valid_q, resolve_valid_d;
  logic              hit_q, hit_d;
  logic [7:0]        res_meta_q, res_meta_d;
  logic [21:0]       res_ptag_q, res_ptag_d;
  logic [WAYS_W-1:0] res_way_q, res_way_d;

  logic [ENTRIES_W-1:0] set_idx;
  logic [TAG_W-1:0]     in_tag;

  assign set_idx = vaddr_input[ENTRIES_W-1:0];
  assign in_tag  = vaddr_input[19:ENTRIES_W];

  logic [WAYS-1:0]   set_hit, asid_eq, glob, res_match, new_match;
  logic              res_found, new_found;
  logic [WAYS_W-1:0] res_sel, new_sel;
  logic [7:0]        res_meta_sel;
  logic [21:0]       res_ptag_sel;

  // Lookup in the indexed set; descending scan makes the lowest matching way win
  always_comb begin
    set_hit      = '0;
    asid_eq      = '0;
    glob         = '0;
    res_match    = '0;
    new_match    = '0;
    res_found    = 1'b0;
    new_found    = 1'b0;
    res_sel      = '0;
    new_sel      = '0;
    res_meta_sel = '0;
    res_ptag_sel = '0;
    for (int w = 0; w < WAYS; w++) begin
      set_hit[w]   = valid_q[set_idx][w] && (tag_q[set_idx][w] == in_tag);
      asid_eq[w]   = (asid_q[set_idx][w] == asid_input);
      glob[w]      = meta_q[set_idx][w][G_BIT];
      res_match[w] = set_hit[w] && (glob[w] || asid_eq[w]);
      // Refill also treats a global incoming page as colliding with any ASID
      new_match[w] = set_hit[w] &&
                     (glob[w] || new_entry_metadata_input[G_BIT] || asid_eq[w]);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (res_match[w]) begin
        res_found    = 1'b1;
        res_sel      = WAYS_W'(w);
        res_meta_sel = meta_q[set_idx][w];
        res_ptag_sel = ptag_q[set_idx][w];
      end
      if (new_match[w]) begin
        new_found = 1'b1;
        new_sel   = WAYS_W'(w);
      end
    end
  end

  logic [WAYS_W-1:0] wr_way;

  // Command decode: next entry state, victim counter and resolve outputs
  always_comb begin
    valid_d         = valid_q;
    tag_d           = tag_q;
    asid_d          = asid_q;
    meta_d          = meta_q;
    ptag_d          = ptag_q;
    victim_d        = victim_q;
    resolve_valid_d = 1'b0;
    hit_d           = hit_q;
    res_meta_d      = res_meta_q;
    res_ptag_d      = res_ptag_q;
    res_way_d       = res_way_q;
    wr_way          = victim_q;

    case (cmd)
      CMD_RESOLVE: begin
        resolve_valid_d = 1'b1;
        hit_d           = res_found;
        res_meta_d      = res_found ? res_meta_sel : 8'd0;
        res_ptag_d      = res_found ? res_ptag_sel : 22'd0;
        res_way_d       = res_found ? res_sel : '0;
      end
      CMD_NEW_ENTRY: begin
        hit_d = 1'b0;
        if (new_found) begin
          wr_way = new_sel;
        end else begin
          wr_way   = victim_q;
          victim_d = (victim_q == WAYS_W'(WAYS - 1)) ? '0 : victim_q + WAYS_W'(1);
        end
        for (int w = 0; w < WAYS; w++) begin
          if (WAYS_W'(w) == wr_way) begin
            valid_d[set_idx][w] = 1'b1;
            tag_d[set_idx][w]   = in_tag;
            asid_d[set_idx][w]  = asid_input;
            meta_d[set_idx][w]  = new_entry_metadata_input;
            ptag_d[set_idx][w]  = new_entry_ptag_input;
          end
        end
      end
      CMD_INVALIDATE_ALL: begin
        hit_d = 1'b0;
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++)
            valid_d[s][w] = 1'b0;
      end
      CMD_INVALIDATE_VADDR: begin
        hit_d = 1'b0;
        for (int w = 0; w < WAYS; w++)
          if (set_hit[w]) valid_d[set_idx][w] = 1'b0;
      end
      CMD_INVALIDATE_ASID: begin
        hit_d = 1'b0;
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++)
            if ((asid_q[s][w] == asid_input) && !meta_q[s][w][G_BIT])
              valid_d[s][w] = 1'b0;
      end
      CMD_INVALIDATE_VA_AS: begin
        hit_d = 1'b0;
        for (int w = 0; w < WAYS; w++)
          if (set_hit[w] && asid_eq[w] && !glob[w])
            valid_d[set_idx][w] = 1'b0;
      end
      default: begin
      end
    endcase
  end

  // State registers; reset clears valids, victim counter and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          valid_q[s][w] <= 1'b0;
      victim_q        <= '0;
      resolve_valid_q <= 1'b0;
      hit_q           <= 1'b0;
      res_meta_q      <= '0;
      res_ptag_q      <= '0;
      res_way_q       <= '0;
    end else begin
      valid_q         <= valid_d;
      tag_q           <= tag_d;
      asid_q          <= asid_d;
      meta_q          <= meta_d;
      ptag_q          <= ptag_d;
      victim_q        <= victim_d;
      resolve_valid_q <= resolve_valid_d;
      hit_q           <= hit_d;
      res_meta_q      <= res_meta_d;
      res_ptag_q      <= res_ptag_d;
      res_way_q       <= res_way_d;
    end
  end

  assign resolve_valid           = resolve_valid_q;
  assign hit                     = hit_q;
  assign resolve_metadata_output = res_meta_q;
  assign resolve_ptag_output     = res_ptag_q;
  assign resolve_way             = res_way_q;

endmodule
